// File: rtl/parking_gate_fsm.sv
// Entrance beam decoder: sync + debounce sensors A/B, track crossings, pulse inc/dec.
// Latency: raw edge -> filtered edge 2+DEBOUNCE_CYCLES, pulse one edge later; no backpressure.
// Optional stall timeout into FAULT when PARKING_GATE_TIMEOUT_EN is defined.
module parking_gate_fsm #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned TIMEOUT_CYCLES  = 1000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sensor_a,
  input  logic       sensor_b,
  output logic [1:0] inc_dec,
  output logic       fault,
  output logic       busy
);

  typedef enum logic [2:0] {
    IDLE, ENTER_A, ENTER_AB, ENTER_B, EXIT_B, EXIT_AB, EXIT_A, FAULT
  } state_t;

  localparam logic [7:0] DB_MAX = 8'(DEBOUNCE_CYCLES);

  // Index 1 is sensor A, index 0 is sensor B, so {a_f, b_f} == filt_q.
  logic [1:0]       sync1_q, sync2_q;
  logic [1:0]       filt_q, filt_d;
  logic [1:0][7:0]  db_cnt_q, db_cnt_d;
  logic             a_f, b_f;

  state_t     state_q, state_d;
  logic [1:0] inc_dec_q, inc_dec_d;
  logic       fault_q, busy_q;
  logic       tmo_hit;

  assign a_f = filt_q[1];
  assign b_f = filt_q[0];

  always_comb begin
    filt_d   = filt_q;
    db_cnt_d = db_cnt_q;
    for (int i = 0; i < 2; i++) begin
      if (sync2_q[i] == filt_q[i]) begin
        db_cnt_d[i] = 8'd0;
      end else if (db_cnt_q[i] + 8'd1 == DB_MAX) begin
        filt_d[i]   = sync2_q[i];
        db_cnt_d[i] = 8'd0;
      end else begin
        db_cnt_d[i] = db_cnt_q[i] + 8'd1;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    inc_dec_d = 2'b00;
    unique case (state_q)
      IDLE:     case (filt_q) 2'b10: state_d = ENTER_A;  2'b01: state_d = EXIT_B;
                                2'b11: state_d = FAULT;    default: ; endcase
      ENTER_A:  case (filt_q) 2'b11: state_d = ENTER_AB; 2'b00: state_d = IDLE;
                                2'b01: state_d = FAULT;    default: ; endcase
      ENTER_AB: case (filt_q) 2'b01: state_d = ENTER_B;  2'b10: state_d = ENTER_A;
                                2'b00: state_d = FAULT;    default: ; endcase
      ENTER_B:  case (filt_q) 2'b00: begin state_d = IDLE; inc_dec_d = 2'b10; end
                                2'b11: state_d = ENTER_AB; 2'b10: state_d = FAULT;
                                default: ; endcase
      EXIT_B:   case (filt_q) 2'b11: state_d = EXIT_AB;  2'b00: state_d = IDLE;
                                2'b10: state_d = FAULT;    default: ; endcase
      EXIT_AB:  case (filt_q) 2'b10: state_d = EXIT_A;   2'b01: state_d = EXIT_B;
                                2'b00: state_d = FAULT;    default: ; endcase
      EXIT_A:   case (filt_q) 2'b00: begin state_d = IDLE; inc_dec_d = 2'b01; end
                                2'b11: state_d = EXIT_AB;  2'b01: state_d = FAULT;
                                default: ; endcase
      FAULT:    if (filt_q == 2'b00) state_d = IDLE;
      default:  state_d = FAULT;
    endcase
    // A stalled sequence is abandoned silently, even if it would have completed now.
    if (tmo_hit) begin
      state_d   = FAULT;
      inc_dec_d = 2'b00;
    end
  end

`ifdef PARKING_GATE_TIMEOUT_EN
  localparam logic [15:0] TMO_MAX = 16'(TIMEOUT_CYCLES);
  logic [15:0] tmo_q, tmo_d;

  assign tmo_hit = (tmo_q == TMO_MAX);

  always_comb begin
    tmo_d = tmo_q + 16'd1;
    if (state_d != state_q || state_q == IDLE || state_q == FAULT) tmo_d = 16'd0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) tmo_q <= 16'd0;
    else       tmo_q <= tmo_d;
  end
`else
  assign tmo_hit = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q   <= 2'b00;
      sync2_q   <= 2'b00;
      filt_q    <= 2'b00;
      db_cnt_q  <= '0;
      state_q   <= IDLE;
      inc_dec_q <= 2'b00;
      fault_q   <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      sync1_q   <= {sensor_a, sensor_b};
      sync2_q   <= sync1_q;
      filt_q    <= filt_d;
      db_cnt_q  <= db_cnt_d;
      state_q   <= state_d;
      inc_dec_q <= inc_dec_d;
      fault_q   <= (state_d == FAULT);
      busy_q    <= (state_d != IDLE) && (state_d != FAULT);
    end
  end

  assign inc_dec = inc_dec_q;
  assign fault   = fault_q;
  assign busy    = busy_q;

endmodule
